jtgng_layer_mixer: RTL and testbench

Parametrised multi-layer colour mixer that replaces the fixed char/scroll/object mixing of the per-game video tops. It takes LAYERS packed pixel codes, resolves priority, and looks up a CPU-writable palette RAM. It drives blanked RGB with matched blanking delays. It sits between the layer generators and the video output, and clears its palette to black after every reset.

---
 rtl/jtgng_mix_pkg.sv | 21 ++
 rtl/jtgng_mix_palram.sv | 23 ++
 rtl/jtgng_layer_mixer.sv | 199 +++++++++++++++++++
 tb/tb_jtgng_layer_mixer.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/jtgng_mix_pkg.sv
// Shared definitions for the layer mixer: FSM states, transparent pen and
// the highest-set-bit helper used for default layer priority.
package jtgng_mix_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } mix_state_t;

    localparam logic [3:0] TRANSP_PEN = 4'hF;

    // Index of the highest set bit; an all-zero mask maps to 0 (the backdrop)
    function automatic logic [2:0] hibit(input logic [7:0] mask);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 0; i < 8; i++)
            if (mask[i]) r = i[2:0];
        return r;
    endfunction

endpackage

// File: rtl/jtgng_mix_palram.sv
// Simple dual-port RAM: write port on every clk, registered read port
// gated by cen. Read-first: a same-cycle write returns the previous data.
module jtgng_mix_palram #(
    parameter int AW = 8,
    parameter int DW = 12
) (
    input  logic          clk,
    input  logic          cen,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] din,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] dout
);

    logic [DW-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we)  mem[waddr] <= din;
        if (cen) dout       <= mem[raddr];
    end

endmodule

// File: rtl/jtgng_layer_mixer.sv
// Parametrised multi-layer colour mixer: priority resolve, palette lookup,
// blanking. Optional CPU priority table enabled by JTGNG_MIX_PRIORAM_EN.
module jtgng_layer_mixer
    import jtgng_mix_pkg::*;
#(
    parameter  int LAYERS = 4,
    parameter  int PXLW   = 6,
    parameter  int COLW   = 4,
    localparam int LW     = $clog2(LAYERS),
    localparam int PALW   = LW + PXLW,
    localparam int PALDW  = 3 * COLW
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cen,
    input  logic                   LHBL,
    input  logic                   LVBL,
    input  logic [LAYERS*PXLW-1:0] pxl_in,
    input  logic [LAYERS-1:0]      layer_en,
    input  logic                   pal_we,
    input  logic [PALW-1:0]        pal_addr,
    input  logic [PALDW-1:0]       pal_din,
`ifdef JTGNG_MIX_PRIORAM_EN
    input  logic                   prio_we,
    input  logic [LAYERS-1:0]      prio_addr,
    input  logic [LW-1:0]          prio_din,
`endif
    output logic [COLW-1:0]        red,
    output logic [COLW-1:0]        green,
    output logic [COLW-1:0]        blue,
    output logic                   LHBL_dly,
    output logic                   LVBL_dly,
    output logic                   ready
);

`ifdef JTGNG_MIX_PRIORAM_EN
    localparam int CW = (LAYERS > PALW) ? LAYERS : PALW;
`else
    localparam int CW = PALW;
`endif
    localparam int NSEL = 2**LW;

    mix_state_t    st;
    logic [CW-1:0] clr_cnt;
    logic          clearing;

    assign clearing = (st == CLEAR);

    // Clear walker: one address per clk, independent of cen
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st      <= CLEAR;
            clr_cnt <= '0;
            ready   <= 1'b0;
        end else begin
            case (st)
                CLEAR: begin
                    clr_cnt <= clr_cnt + 1'b1;
                    if (clr_cnt == {CW{1'b1}}) begin
                        st    <= RUN;
                        ready <= 1'b1;
                    end
                end
                RUN:     ready <= 1'b1;
                default: st    <= CLEAR;
            endcase
        end
    end

    logic             pal_wr_we;
    logic [PALW-1:0]  pal_wr_addr;
    logic [PALDW-1:0] pal_wr_din;

    always_comb begin
        pal_wr_we   = pal_we;
        pal_wr_addr = pal_addr;
        pal_wr_din  = pal_din;
        if (clearing) begin
            pal_wr_we   = 32'(clr_cnt) < (1 << PALW);
            pal_wr_addr = clr_cnt[PALW-1:0];
            pal_wr_din  = '0;
        end
    end

    // S1: input capture
    logic [LAYERS*PXLW-1:0] pxl_s1;
    logic [LAYERS-1:0]      en_s1;
    logic                   hb_s1, vb_s1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pxl_s1 <= '0;
            en_s1  <= '0;
            hb_s1  <= 1'b0;
            vb_s1  <= 1'b0;
        end else if (cen) begin
            pxl_s1 <= pxl_in;
            en_s1  <= layer_en;
            hb_s1  <= LHBL;
            vb_s1  <= LVBL;
        end
    end

    // S2: opaque mask and per-layer effective codes
    logic [LAYERS-1:0] opaque;
    logic [PXLW-1:0]   code_nx [NSEL];

    always_comb begin
        opaque = '0;
        for (int i = 0; i < NSEL; i++) code_nx[i] = '0;
        opaque[0]  = 1'b1;
        code_nx[0] = en_s1[0] ? pxl_s1[0 +: PXLW] : '0;
        for (int i = 1; i < LAYERS; i++) begin
            opaque[i]  = en_s1[i] && (pxl_s1[i*PXLW +: 4] != TRANSP_PEN);
            code_nx[i] = pxl_s1[i*PXLW +: PXLW];
        end
    end

    logic [PXLW-1:0] code_s2 [NSEL];
    logic [LW-1:0]   win_s2;
    logic            hb_s2, vb_s2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NSEL; i++) code_s2[i] <= '0;
            hb_s2 <= 1'b0;
            vb_s2 <= 1'b0;
        end else if (cen) begin
            for (int i = 0; i < NSEL; i++) code_s2[i] <= code_nx[i];
            hb_s2 <= hb_s1;
            vb_s2 <= vb_s1;
        end
    end

`ifdef JTGNG_MIX_PRIORAM_EN
    logic              prio_wr_we;
    logic [LAYERS-1:0] prio_wr_addr;
    logic [LW-1:0]     prio_wr_din;

    // Cleared entries hold the same answer as the fixed priority
    always_comb begin
        prio_wr_we   = prio_we;
        prio_wr_addr = prio_addr;
        prio_wr_din  = prio_din;
        if (clearing) begin
            prio_wr_we   = 32'(clr_cnt) < (1 << LAYERS);
            prio_wr_addr = clr_cnt[LAYERS-1:0];
            prio_wr_din  = LW'(hibit(8'(clr_cnt[LAYERS-1:0])));
        end
    end

    jtgng_mix_palram #(.AW(LAYERS), .DW(LW)) u_prio (
        .clk   (clk),
        .cen   (cen),
        .we    (prio_wr_we),
        .waddr (prio_wr_addr),
        .din   (prio_wr_din),
        .raddr (opaque),
        .dout  (win_s2)
    );
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   win_s2 <= '0;
        else if (cen) win_s2 <= LW'(hibit(8'(opaque)));
    end
`endif

    // S3: palette read, blanking aligned to the read data
    logic [PALW-1:0]  pal_raddr;
    logic [PALDW-1:0] pal_dout;
    logic             show;

    assign pal_raddr = {win_s2, code_s2[win_s2]};

    jtgng_mix_palram #(.AW(PALW), .DW(PALDW)) u_pal (
        .clk   (clk),
        .cen   (cen),
        .we    (pal_wr_we),
        .waddr (pal_wr_addr),
        .din   (pal_wr_din),
        .raddr (pal_raddr),
        .dout  (pal_dout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            LHBL_dly <= 1'b0;
            LVBL_dly <= 1'b0;
        end else if (cen) begin
            LHBL_dly <= hb_s2;
            LVBL_dly <= vb_s2;
        end
    end

    // RAM output is not reset, so colour is gated by the reset-cleared flags
    assign show = ready & LHBL_dly & LVBL_dly;
    assign {red, green, blue} = show ? pal_dout : '0;

endmodule

// File: tb/tb_jtgng_layer_mixer.sv
// Self-checking bench for jtgng_layer_mixer (LAYERS=4, PXLW=6, COLW=4);
// covers the priority table too when JTGNG_MIX_PRIORAM_EN is defined.
module tb_jtgng_layer_mixer;

    logic        clk = 1'b0, rst_n = 1'b0, cen = 1'b0;
    logic        LHBL = 1'b1, LVBL = 1'b1;
    logic [23:0] pxl_in = '0;
    logic [3:0]  layer_en = 4'hF;
    logic        pal_we = 1'b0;
    logic [7:0]  pal_addr = '0;
    logic [11:0] pal_din = '0;
`ifdef JTGNG_MIX_PRIORAM_EN
    logic        prio_we = 1'b0;
    logic [3:0]  prio_addr = '0;
    logic [1:0]  prio_din = '0;
`endif
    logic [3:0]  red, green, blue;
    logic        LHBL_dly, LVBL_dly, ready;

    jtgng_layer_mixer #(.LAYERS(4), .PXLW(6), .COLW(4)) dut (
        .clk(clk), .rst_n(rst_n), .cen(cen), .LHBL(LHBL), .LVBL(LVBL),
        .pxl_in(pxl_in), .layer_en(layer_en),
        .pal_we(pal_we), .pal_addr(pal_addr), .pal_din(pal_din),
`ifdef JTGNG_MIX_PRIORAM_EN
        .prio_we(prio_we), .prio_addr(prio_addr), .prio_din(prio_din),
`endif
        .red(red), .green(green), .blue(blue),
        .LHBL_dly(LHBL_dly), .LVBL_dly(LVBL_dly), .ready(ready)
    );

    always #5 clk = ~clk;

    int passed = 0, total = 0, fails = 0;
    logic [11:0] pal_m [256];
    logic [1:0]  prio_m [16];
    logic [13:0] expq [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [1:0] top_bit(input logic [3:0] m);
        logic [1:0] r = 2'd0;
        for (int i = 0; i < 4; i++) if (m[i]) r = 2'(i);
        return r;
    endfunction

    function automatic void model_reset();
        for (int a = 0; a < 256; a++) pal_m[a] = '0;
        for (int m = 0; m < 16; m++) prio_m[m] = top_bit(4'(m));
    endfunction

    // Expected {hblank, vblank, rgb} for one pixel, straight from the mixing rules
    function automatic logic [13:0] model(input logic [23:0] px, input logic [3:0] en,
                                          input logic hb, input logic vb);
        logic [3:0] mask = 4'b0001;
        logic [1:0] w;
        logic [5:0] code;
        for (int i = 1; i < 4; i++)
            if (en[i] && px[i*6 +: 4] != 4'hF) mask[i] = 1'b1;
`ifdef JTGNG_MIX_PRIORAM_EN
        w = prio_m[mask];
`else
        w = top_bit(mask);
`endif
        code = px[w*6 +: 6];
        if (w == 2'd0 && !en[0]) code = '0;
        return {hb, vb, (hb && vb) ? pal_m[{w, code}] : 12'h000};
    endfunction

    task automatic pix(input logic [23:0] px, input logic [3:0] en, input logic hb, input logic vb);
        logic [13:0] e;
        pxl_in = px; layer_en = en; LHBL = hb; LVBL = vb; cen = 1'b1;
        tick();
        cen = 1'b0;
        expq.push_back(model(px, en, hb, vb));
        if (expq.size() == 3) begin
            e = expq.pop_front();
            check("rgb", {red, green, blue}, e[11:0]);
            check("hbl", LHBL_dly, e[13]);
            check("vbl", LVBL_dly, e[12]);
        end
    endtask

    task automatic pal_wr(input logic [7:0] a, input logic [11:0] d);
        pal_we = 1'b1; pal_addr = a; pal_din = d;
        tick();
        pal_we = 1'b0;
        pal_m[a] = d;
    endtask

`ifdef JTGNG_MIX_PRIORAM_EN
    task automatic prio_wr(input logic [3:0] a, input logic [1:0] d);
        prio_we = 1'b1; prio_addr = a; prio_din = d;
        tick();
        prio_we = 1'b0;
        prio_m[a] = d;
    endtask
`endif

    task automatic wait_ready(input string tag);
        int n = 0;
        while (!ready && n < 1000) begin
            tick();
            n++;
        end
        check(tag, n, 256);
    endtask

    function automatic logic [23:0] rnd_pix();
        logic [23:0] p;
        for (int i = 0; i < 4; i++)
            p[i*6 +: 6] = ($urandom_range(0, 2) == 0) ? {2'($urandom), 4'hF} : 6'($urandom);
        return p;
    endfunction

    localparam logic [23:0] PX_PRIO = {6'h0F, 6'h05, 6'h03, 6'h01};
    localparam logic [23:0] PX_COL  = {6'h0F, 6'h0F, 6'h05, 6'h00};

    initial begin
        model_reset();
        #1;
        check("rst_ready", ready, 0);
        check("rst_rgb", {red, green, blue}, 0);
        check("rst_hbl", LHBL_dly, 0);
        check("rst_vbl", LVBL_dly, 0);
        tick(); tick();
        rst_n = 1'b1;
        wait_ready("clear_len");

        // Every palette entry reads back as black after the clear
        for (int a = 0; a < 256; a++) begin
            logic [23:0] p = {6'h0F, 6'h0F, 6'h0F, 6'h00};
            p[(a >> 6) * 6 +: 6] = 6'(a);
            pix(p, 4'hF, 1'b1, 1'b1);
        end

        // Priority: layer 3 transparent, layer 2 wins
        expq.delete();
        pal_wr(8'h85, 12'hF80);
        pal_wr(8'h43, 12'h3C5);
        repeat (3) pix(PX_PRIO, 4'hF, 1'b1, 1'b1);
        check("prio_rgb", {red, green, blue}, 12'hF80);
        repeat (3) pix(PX_PRIO, 4'b1011, 1'b1, 1'b1);
        check("dbg_en_rgb", {red, green, blue}, 12'h3C5);

        // Single-pixel horizontal blank
        for (int k = 0; k < 6; k++) begin
            pix(PX_PRIO, 4'hF, (k != 1), 1'b1);
            if (k >= 2 && k <= 4) begin
                check("blank_hbl", LHBL_dly, (k != 3));
                check("blank_rgb", {red, green, blue}, (k == 3) ? 12'h000 : 12'hF80);
            end
        end

        // Read/write collision on the same palette address
        pal_wr(8'h45, 12'h123);
        expq.delete();
        pxl_in = PX_COL; layer_en = 4'hF; LHBL = 1'b1; LVBL = 1'b1;
        cen = 1'b1;
        tick(); tick();
        pal_we = 1'b1; pal_addr = 8'h45; pal_din = 12'hABC;
        tick();
        pal_we = 1'b0;
        check("coll_old", {red, green, blue}, 12'h123);
        tick();
        check("coll_new", {red, green, blue}, 12'hABC);
        cen = 1'b0;
        pal_m[8'h45] = 12'hABC;

        // cen held low: pipeline frozen while inputs change
        for (int k = 0; k < 5; k++) begin
            pxl_in = rnd_pix(); LHBL = 1'(k); tick();
        end
        check("hold_rgb", {red, green, blue}, 12'hABC);
        check("hold_hbl", LHBL_dly, 1);

`ifdef JTGNG_MIX_PRIORAM_EN
        expq.delete();
        prio_wr(4'b0111, 2'd1);
        repeat (3) pix(PX_PRIO & ~24'hFC0000 | {6'h0F, 18'h0}, 4'hF, 1'b1, 1'b1);
        check("prioram_rgb", {red, green, blue}, 12'h3C5);
`endif

        // Random palette contents and random pixel stream
        expq.delete();
        for (int k = 0; k < 40; k++) pal_wr(8'($urandom), 12'($urandom));
        for (int k = 0; k < 200; k++)
            pix(rnd_pix(), 4'($urandom) | 4'($urandom), ($urandom_range(0, 7) != 0),
                ($urandom_range(0, 15) != 0));

        // Reset in the middle of a frame
        pix(PX_PRIO, 4'hF, 1'b1, 1'b1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_ready", ready, 0);
        check("mid_rst_rgb", {red, green, blue}, 0);
        check("mid_rst_hbl", LHBL_dly, 0);
        check("mid_rst_vbl", LVBL_dly, 0);
        tick();
        rst_n = 1'b1;
        model_reset();
        expq.delete();
        wait_ready("reclear_len");
        repeat (3) pix(PX_PRIO, 4'hF, 1'b1, 1'b1);
        check("reclear_rgb", {red, green, blue}, 12'h000);

`ifdef JTGNG_MIX_PRIORAM_EN
        expq.delete();
        pal_wr(8'h83, 12'h777);
        pal_wr(8'h43, 12'h111);
        repeat (3) pix({6'h0F, 6'h03, 6'h03, 6'h03}, 4'hF, 1'b1, 1'b1);
        check("prio_default", {red, green, blue}, 12'h777);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
